hamming74_rx: RTL and testbench
===============================

# hamming74_rx

Serial receive stage paired with the 7-bit parallel-to-serial transmit shifter. It collects 7-bit Hamming(7,4) codewords arriving LSB-first and corrects any single-bit error. It then presents the 4-bit payload on a ready/valid output with a one-entry holding buffer. It sits directly downstream of the transmit shifter's serial output, or of the channel model that carries it, and feeds the secure-comm payload path.

## Interface
No parameters; codeword length is fixed at 7 bits and payload at 4 bits.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset; clears all state
- din  in  1  serial codeword bit
- din_valid  in  1  din qualifier; one bit is accepted per cycle with din_valid=1
- sof  in  1  start of frame; meaningful only with din_valid=1; marks din as codeword bit 0
- dout  out  4  corrected payload {d4,d3,d2,d1}
- dout_valid  out  1  dout, syndrome and corrected are valid
- dout_ready  in  1  consumer accepts the word when dout_valid & dout_ready
- syndrome  out  3  {s4,s2,s1} of the held word; 0 means no error
- corrected  out  1  a bit of the held word was flipped (syndrome != 0)
- overflow  out  1  sticky: a completed word was dropped because the buffer was full

## Operation
- Codeword bit order matches the transmitter: c[0] arrives first.
- Bit map: c0=p1, c1=p2, c2=d1, c3=p4, c4=d2, c5=d3, c6=d4.
- Syndrome:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
- If the syndrome S is nonzero, invert c[S-1] and then extract the payload.
- Double errors are not detected; they are miscorrected by design.
- Receiver FSM has two states, IDLE and RECV, plus a 3-bit bit counter cnt.
  - IDLE: din_valid & sof stores din as c0, sets cnt=1, and moves to RECV. din_valid without sof is ignored.
  - RECV, din_valid & !sof: stores din at c[cnt] and increments cnt.
  - RECV, din_valid & sof: aborts the partial word with no output, stores din as c0, sets cnt=1, and stays in RECV.
  - RECV, din_valid=0: holds state; there is no timeout.
  - When the accepted bit is the 7th (cnt==6), the word completes, cnt clears, and the FSM returns to IDLE.
  - Back-to-back frames need sof on every frame's first bit.
- Output buffer holds one entry.
  - On completion with the buffer empty, or being emptied in the same cycle (dout_valid & dout_ready), load dout, syndrome and corrected from the 7th bit plus stored bits, and set dout_valid.
  - On completion with the buffer full and dout_ready=0, drop the new word, keep the held word unchanged, and set overflow.
  - Receive continues while the buffer is full; it is independent of the output side.
- dout, syndrome and corrected are stable while dout_valid=1 and dout_ready=0.
- overflow clears only on reset.

## Timing
- Reset values: dout=0, dout_valid=0, syndrome=0, corrected=0, overflow=0. The FSM goes to IDLE, cnt=0, and the shift storage clears.
- Reset asserted mid-frame discards the partial word. A held but unconsumed word is also lost.
- Latency:
  - dout_valid rises the cycle after the edge that samples the 7th bit.
  - A minimum frame is 7 consecutive din_valid cycles, with dout_valid high on cycle 8.
- Handshake:
  - A transfer occurs on an edge with dout_valid & dout_ready.
  - dout_valid drops the next cycle unless a word completes on that same edge.
  - A completing word in that case loads seamlessly, keeping dout_valid high with new data.
- Throughput: one word per 7 cycles sustained, with no bubble required between frames.
- Simultaneous completion and consume: the new word is taken and overflow is not set.
- dout_ready has no effect while dout_valid=0.

## Test plan
- Clean word:
  - Stimulus: payload 4'b1011, codeword 7'h55, sent c0 first as bits 1,0,1,0,1,0,1, with sof on the first bit and dout_ready=1.
  - Required: cycle 8 shows dout=4'b1011, syndrome=0, corrected=0, and dout_valid high for exactly one cycle.
- Single error sweep:
  - Stimulus: codeword 7'h45 (c4 flipped).
  - Required: dout=4'b1011, syndrome=3'd5, corrected=1.
  - Repeat the flip for every bit position 0-6; each gives dout=4'b1011 with syndrome equal to position+1.
- Backpressure and overflow:
  - Stimulus: dout_ready=0, two back-to-back frames 7'h55 then 7'h00.
  - Required: dout holds 4'b1011, and overflow=1 after the second frame completes.
  - Then raise dout_ready for 1 cycle: dout_valid drops, and 4'h0 is never presented.
- Resync:
  - Stimulus: send 4 bits, then reassert sof and send full frame 7'h00.
  - Required: exactly one output, dout=0, syndrome=0.
- Gaps and reset:
  - Stimulus: frame 7'h55 with din_valid low every other cycle.
  - Required: dout=4'b1011 one cycle after the 7th valid bit.
  - Stimulus: assert rst after 3 bits, then release and send a full frame.
  - Required: after rst all outputs are 0 and no word is emitted; the following full frame decodes correctly.
- Simultaneous consume and complete:
  - Stimulus: hold a word, and assert dout_ready on the same edge a new frame completes.
  - Required: dout_valid stays 1, dout updates to the new payload, and overflow stays 0.

Source files
------------

// File: rtl/hamming74_rx.sv
// Serial Hamming(7,4) receiver: collects LSB-first codewords, corrects any
// single-bit error and presents the payload through a one-entry ready/valid buffer.
module hamming74_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sof,
    output logic [3:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [2:0] syndrome,
    output logic       corrected,
    output logic       overflow
);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] sh_q, sh_d;
    logic [3:0] dout_q, dout_d;
    logic [2:0] syn_q, syn_d;
    logic       corr_q, corr_d;
    logic       vld_q, vld_d;
    logic       ovf_q, ovf_d;

    logic       take_first, take_next, complete;
    logic [6:0] cw, cw_fix;
    logic [2:0] syn;
    logic       load, drop;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; sof always restarts a frame, even mid-word
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_first) state_d = RECV;
            RECV:    if (complete)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        take_first = din_valid & sof;
        take_next  = din_valid & ~sof & (state_q == RECV);
        complete   = take_next & (cnt_q == 3'd6);
    end

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (take_first) begin
            sh_d[0] = din;
            cnt_d   = 3'd1;
        end else if (take_next) begin
            if (complete) begin
                cnt_d = 3'd0;
            end else begin
                sh_d[cnt_q] = din;
                cnt_d       = cnt_q + 3'd1;
            end
        end
    end

    // The 7th bit is decoded straight off din; it never lands in the shift storage
    always_comb begin
        cw     = {din, sh_q};
        syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        for (int i = 0; i < 7; i++)
            cw_fix[i] = cw[i] ^ (syn == 3'(i + 1));
    end

    always_comb begin
        load   = complete & (~vld_q | dout_ready);
        drop   = complete & vld_q & ~dout_ready;
        dout_d = dout_q;
        syn_d  = syn_q;
        corr_d = corr_q;
        vld_d  = vld_q;
        if (load) begin
            dout_d = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
            syn_d  = syn;
            corr_d = (syn != 3'd0);
            vld_d  = 1'b1;
        end else if (vld_q & dout_ready) begin
            vld_d = 1'b0;
        end
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 3'd0;
            sh_q   <= 6'd0;
            dout_q <= 4'd0;
            syn_q  <= 3'd0;
            corr_q <= 1'b0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            dout_q <= dout_d;
            syn_q  <= syn_d;
            corr_q <= corr_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dout       = dout_q;
    assign syndrome   = syn_q;
    assign corrected  = corr_q;
    assign dout_valid = vld_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_hamming74_rx.sv
// Directed bench for hamming74_rx: expected words go into a scoreboard queue as
// frames are sent and are popped by a monitor on every output transfer.
module tb_hamming74_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic [2:0] syndrome;
    logic       corrected;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];   // {dout, syndrome, corrected}

    hamming74_rx dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .syndrome(syndrome), .corrected(corrected), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic cyc(input logic v, input logic s, input logic d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [6:0] cw);
        for (int i = 0; i < 7; i++) cyc(1'b1, i == 0, cw[i]);
    endtask

    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 32'(sb.size()), 32'd1);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                chk("sb_dout", 32'(dout), 32'(e[7:4]));
                chk("sb_syndrome", 32'(syndrome), 32'(e[3:1]));
                chk("sb_corrected", 32'(corrected), 32'(e[0]));
            end
        end
    end

    initial begin
        logic [6:0] one;
        logic [6:0] w55;
        one = 7'd1;
        w55 = 7'h55;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_syndrome", 32'(syndrome), 32'd0);
        chk("rst_corrected", 32'(corrected), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        cyc(0, 0, 0);

        // Clean word, latency and single-cycle valid
        dout_ready = 1'b1;
        sb.push_back({4'b1011, 3'd0, 1'b0});
        send_frame(w55);
        chk("clean_valid_cycle8", 32'(dout_valid), 32'd1);
        chk("clean_dout", 32'(dout), 32'hb);
        cyc(0, 0, 0);
        chk("clean_valid_one_cycle", 32'(dout_valid), 32'd0);

        // Single-error sweep, frames back to back
        for (int p = 0; p < 7; p++) begin
            sb.push_back({4'b1011, 3'(p + 1), 1'b1});
            send_frame(w55 ^ (one << p));
        end
        cyc(0, 0, 0);
        chk("sweep_drained", 32'(sb.size()), 32'd0);

        // Backpressure and overflow
        dout_ready = 1'b0;
        sb.push_back({4'b1011, 3'd0, 1'b0});
        send_frame(w55);
        send_frame(7'h00);
        chk("bp_valid", 32'(dout_valid), 32'd1);
        chk("bp_dout_held", 32'(dout), 32'hb);
        chk("bp_overflow", 32'(overflow), 32'd1);
        dout_ready = 1'b1;
        cyc(0, 0, 0);
        dout_ready = 1'b0;
        chk("bp_valid_dropped", 32'(dout_valid), 32'd0);
        repeat (3) cyc(0, 0, 0);
        chk("bp_no_second_word", 32'(dout_valid), 32'd0);
        chk("bp_overflow_sticky", 32'(overflow), 32'd1);

        // Reset clears overflow
        rst = 1'b0;
        #1;
        chk("rst2_overflow", 32'(overflow), 32'd0);
        cyc(0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0);

        // Resync: partial frame aborted by a new sof
        dout_ready = 1'b1;
        sb.push_back({4'b0000, 3'd0, 1'b0});
        cyc(1, 1, 1);
        repeat (3) cyc(1, 0, 1);
        send_frame(7'h00);
        cyc(0, 0, 0);
        repeat (2) cyc(0, 0, 0);
        chk("resync_one_word", 32'(sb.size()), 32'd0);

        // Gaps between valid bits
        sb.push_back({4'b1011, 3'd0, 1'b0});
        for (int i = 0; i < 7; i++) begin
            cyc(1, i == 0, w55[i]);
            if (i < 6) cyc(0, 0, 0);
        end
        chk("gap_valid", 32'(dout_valid), 32'd1);
        chk("gap_dout", 32'(dout), 32'hb);
        cyc(0, 0, 0);

        // Reset mid-frame discards the partial word
        for (int i = 0; i < 3; i++) cyc(1, i == 0, w55[i]);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(dout_valid), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_syndrome", 32'(syndrome), 32'd0);
        cyc(0, 0, 0);
        rst = 1'b1;
        for (int i = 3; i < 7; i++) cyc(1, 0, w55[i]);
        cyc(0, 0, 0);
        chk("midrst_no_word", 32'(dout_valid), 32'd0);
        sb.push_back({4'b1011, 3'd4, 1'b1});
        send_frame(w55 ^ 7'h08);
        chk("postrst_valid", 32'(dout_valid), 32'd1);
        cyc(0, 0, 0);

        // Simultaneous consume and complete
        dout_ready = 1'b0;
        sb.push_back({4'b1011, 3'd0, 1'b0});
        send_frame(w55);
        cyc(0, 0, 0);
        chk("sim_held", 32'(dout_valid), 32'd1);
        sb.push_back({4'b0000, 3'd0, 1'b0});
        for (int i = 0; i < 6; i++) cyc(1, i == 0, 1'b0);
        dout_ready = 1'b1;
        cyc(1, 0, 0);
        chk("sim_valid_stays", 32'(dout_valid), 32'd1);
        chk("sim_dout_new", 32'(dout), 32'd0);
        chk("sim_overflow", 32'(overflow), 32'd0);
        cyc(0, 0, 0);
        dout_ready = 1'b0;
        chk("sim_drained_valid", 32'(dout_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
